// File: rtl/sn257_arb_pkg.sv
// Shared types and constants for the SN74XX257 mux arbiter.
// The macro SN257_ARB_TIMEOUT_EN (see sn257_arbiter.sv) adds hold-time preemption.
package sn257_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TURN    = 2'd1,
    DRIVE_A = 2'd2,
    DRIVE_B = 2'd3
  } arb_state_t;

  localparam logic SEL_A  = 1'b0;
  localparam logic SEL_B  = 1'b1;
  localparam logic OE_ON  = 1'b0;
  localparam logic OE_OFF = 1'b1;

  localparam int DEAD_W = 4;
  localparam int HOLD_W = 8;

  // Side to serve when leaving IDLE: a lone requester wins, a tie goes
  // to the side that did not own the mux last.
  function automatic logic pick_target(input logic req_a, input logic req_b,
                                       input logic last);
    logic t;
    if (req_a && req_b) begin
      t = (last == SEL_A) ? SEL_B : SEL_A;
    end else if (req_b) begin
      t = SEL_B;
    end else begin
      t = SEL_A;
    end
    return t;
  endfunction

endpackage

// File: rtl/sn257_arb_cnt.sv
// Loadable up-counter that saturates at all-ones; tc is high once the
// count has reached term (and stays high while saturated past it).
module sn257_arb_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count >= term);

endmodule

// File: rtl/sn257_arbiter.sv
// Break-before-make arbiter driving the sel/oe_n pins of one SN74XX257.
// Build with SN257_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles.
//
// Handshake: a requester holds req_x high for as long as it wants the mux;
// gnt_x high means its input is selected and the mux output is enabled. The
// grant may arrive any number of cycles later and is withdrawn one edge after
// req_x is seen low (or on preemption); requesters must not assume data is
// driven until gnt_x is sampled high.
module sn257_arbiter
  import sn257_arb_pkg::*;
#(
  parameter int DEAD_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       sel,
  output logic       oe_n,
  output arb_state_t dbg_state
);

  if ((DEAD_CYCLES < 1) || (DEAD_CYCLES > 15)) begin : g_bad_dead
    $error("sn257_arbiter: DEAD_CYCLES must be 1..15");
  end
  if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_hold
    $error("sn257_arbiter: MAX_HOLD must be 1..255");
  end

  localparam logic [DEAD_W-1:0] DEAD_TERM = DEAD_W'(DEAD_CYCLES - 1);

  arb_state_t state, state_nx;
  logic       sel_nx, oe_n_nx, gnt_a_nx, gnt_b_nx;
  logic       last, last_nx;
  logic       dead_clr, dead_tc;
  logic       preempt_a, preempt_b;
  logic       driving;

  assign driving = (state == DRIVE_A) || (state == DRIVE_B);

  // Dead time: cleared whenever TURN is entered, counts only inside TURN.
  sn257_arb_cnt #(.W(DEAD_W)) u_dead (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dead_clr),
    .en    (state == TURN),
    .term  (DEAD_TERM),
    .tc    (dead_tc)
  );

`ifdef SN257_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(MAX_HOLD - 1);
  logic hold_tc;

  // Cleared on the TURN->DRIVE edge; tc marks the MAX_HOLD-th granted cycle.
  sn257_arb_cnt #(.W(HOLD_W)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == TURN) && dead_tc),
    .en    (driving),
    .term  (HOLD_TERM),
    .tc    (hold_tc)
  );

  assign preempt_a = hold_tc && req_b;
  assign preempt_b = hold_tc && req_a;
`else
  assign preempt_a = 1'b0;
  assign preempt_b = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= SEL_A;
      oe_n  <= OE_OFF;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      last  <= SEL_B;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      oe_n  <= oe_n_nx;
      gnt_a <= gnt_a_nx;
      gnt_b <= gnt_b_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    oe_n_nx  = oe_n;
    gnt_a_nx = gnt_a;
    gnt_b_nx = gnt_b;
    last_nx  = last;
    dead_clr = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_a || req_b) begin
          state_nx = TURN;
          sel_nx   = pick_target(req_a, req_b, last);
          dead_clr = 1'b1;
        end
      end

      // sel already points at the target; requests are deliberately ignored
      // here so the dead time always completes before anything is driven.
      TURN: begin
        if (dead_tc) begin
          state_nx = (sel == SEL_B) ? DRIVE_B : DRIVE_A;
          oe_n_nx  = OE_ON;
          gnt_a_nx = (sel == SEL_A);
          gnt_b_nx = (sel == SEL_B);
          last_nx  = sel;
        end
      end

      DRIVE_A: begin
        if (!req_a || preempt_a) begin
          oe_n_nx  = OE_OFF;
          gnt_a_nx = 1'b0;
          if (req_b) begin
            state_nx = TURN;
            sel_nx   = SEL_B;
            dead_clr = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      DRIVE_B: begin
        if (!req_b || preempt_b) begin
          oe_n_nx  = OE_OFF;
          gnt_b_nx = 1'b0;
          if (req_a) begin
            state_nx = TURN;
            sel_nx   = SEL_A;
            dead_clr = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign dbg_state = state;

endmodule
